// File: rtl/aes_cipher_state_pkg.sv
// Shared constants and types for the iterative AES forward cipher.
//   Nb / Nr       : column count and round count (AES-128 build: Nr = 10)
//   NKW           : number of 32-bit words in the expanded key schedule
//   C_IDLE/C_ROUND/C_FINAL : controller state encodings
//   cipher_reg_t  : controller register (state, round counter, ready flag).
//                   Hierarchical probes can bind to it to observe the FSM.
//   xtime         : multiply-by-x in GF(2^8), polynomial 0x11B
package aes_cipher_state_pkg;

   localparam int Nb  = 4;
   localparam int Nr  = 10;
   localparam int NKW = Nb * (Nr + 1);

   localparam logic [3:0] NR_L = 4'(Nr);

   localparam logic [1:0] C_IDLE  = 2'd0;
   localparam logic [1:0] C_ROUND = 2'd1;
   localparam logic [1:0] C_FINAL = 2'd2;

   // Byte 4c+r holds row r, column c.
   typedef logic [4*Nb-1:0][7:0] block_t;

   typedef struct packed {
      logic [1:0] state;
      logic [3:0] round;
      logic       ready;
   } cipher_reg_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

endpackage

// File: rtl/aes_cipher_state_mcol.sv
// Forward AES MixColumns on a full 16-byte state, purely combinational.
//   state : input block, byte 4c+r = row r, column c
//   mixed : each column multiplied by the circulant {2,3,1,1} over GF(2^8)
module aes_cipher_state_mcol
   import aes_cipher_state_pkg::*;
(
   input  block_t state,
   output block_t mixed
);

   logic [7:0] a0, a1, a2, a3;

   always_comb begin
      mixed = '0;
      a0    = '0;
      a1    = '0;
      a2    = '0;
      a3    = '0;
      for (int c = 0; c < Nb; c++) begin
         a0 = state[4*c+0];
         a1 = state[4*c+1];
         a2 = state[4*c+2];
         a3 = state[4*c+3];
         // 3*b is computed as xtime(b) ^ b.
         mixed[4*c+0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mixed[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mixed[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mixed[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
   end

endmodule

// File: rtl/aes_cipher_state.sv
// Iterative AES forward cipher: one round per clock, Nr+1 cycles per block.
//   rst       : asynchronous active-low reset
//   clk       : rising-edge clock
//   SBox      : forward S-box table, entry i = SubBytes(i)
//   KExp      : expanded key, word 4*i+c = round i column c, byte r = [31-8r -: 8]
//   Data_in   : plaintext, byte 4c+r = row r, column c
//   Enable    : start request, only looked at while idle
//   Data_out  : ciphertext, same byte order as Data_in
//   Ready_out : one-cycle pulse, Data_out holds a valid ciphertext
//   Busy_out  : high while a block is in flight
// Build option AES_CIPHER_OUT_REG_EN: adds an output register loaded on the
// final round so Data_out holds the last ciphertext until the next completion.
// Without it Data_out is the live state register and shows every round.
//
// Handshake: a block is accepted on any rising edge where Enable=1 and the
// controller is idle (this includes the Ready_out cycle, so Enable held high
// gives back-to-back blocks). Enable while busy is dropped, never queued.
// KExp must stay stable from accept until Ready_out.
module aes_cipher_state
   import aes_cipher_state_pkg::*;
(
   input  logic                  rst,
   input  logic                  clk,
   input  logic [255:0][7:0]     SBox,
   input  logic [NKW-1:0][31:0]  KExp,
   input  block_t                Data_in,
   input  logic                  Enable,
   output block_t                Data_out,
   output logic                  Ready_out,
   output logic                  Busy_out
);

   cipher_reg_t cur, nxt;
   block_t      s_q, s_nxt;
   block_t      sub_sr, mixed, rkey;
   logic [5:0]  kidx;
   logic [31:0] kword;

`ifdef AES_CIPHER_OUT_REG_EN
   block_t      out_q;
`endif

   // Round key and SubBytes+ShiftRows. The round counter is 0 while idle and
   // Nr in the final round, so it directly selects the key for every state.
   always_comb begin
      rkey   = '0;
      sub_sr = '0;
      kidx   = '0;
      kword  = '0;
      for (int c = 0; c < Nb; c++) begin
         kidx  = {cur.round, 2'b00} + 6'(c);
         kword = KExp[kidx];
         for (int r = 0; r < 4; r++) begin
            rkey[4*c+r]   = kword[31-8*r -: 8];
            // Row r rotates left by r columns.
            sub_sr[4*c+r] = SBox[s_q[4*((c+r)%Nb)+r]];
         end
      end
   end

   aes_cipher_state_mcol u_mcol (
      .state (sub_sr),
      .mixed (mixed)
   );

   always_comb begin
      nxt       = cur;
      nxt.ready = 1'b0;
      s_nxt     = s_q;
      case (cur.state)
         C_IDLE: begin
            if (Enable) begin
               s_nxt     = Data_in ^ rkey;
               nxt.round = 4'd1;
               nxt.state = (NR_L == 4'd1) ? C_FINAL : C_ROUND;
            end
         end
         C_ROUND: begin
            s_nxt     = mixed ^ rkey;
            nxt.round = cur.round + 4'd1;
            if (cur.round == NR_L - 4'd1) begin
               nxt.state = C_FINAL;
            end
         end
         C_FINAL: begin
            s_nxt     = sub_sr ^ rkey;
            nxt.ready = 1'b1;
            nxt.state = C_IDLE;
            nxt.round = 4'd0;
         end
         default: begin
            nxt.state = C_IDLE;
            nxt.round = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur   <= '{state: C_IDLE, round: 4'd0, ready: 1'b0};
         s_q   <= '0;
`ifdef AES_CIPHER_OUT_REG_EN
         out_q <= '0;
`endif
      end else begin
         cur <= nxt;
         s_q <= s_nxt;
`ifdef AES_CIPHER_OUT_REG_EN
         if (cur.state == C_FINAL) begin
            out_q <= s_nxt;
         end
`endif
      end
   end

`ifdef AES_CIPHER_OUT_REG_EN
   assign Data_out  = out_q;
`else
   assign Data_out  = s_q;
`endif
   assign Ready_out = cur.ready;
   assign Busy_out  = (cur.state != C_IDLE);

endmodule

// File: tb/tb_aes_cipher_state.sv
// Bench for aes_cipher_state: reference AES-128 model on 4x4 byte arrays with
// a generated S-box and key expansion, a per-cycle compare process, and
// directed plus randomized block sequences.
module tb_aes_cipher_state;
   import aes_cipher_state_pkg::*;

   localparam int LAT = Nr + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [255:0][7:0]    sbox;
   logic [NKW-1:0][31:0] kexp;
   block_t               din;
   logic                 Enable;
   block_t               dout;
   logic                 Ready_out;
   logic                 Busy_out;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [31:0]  cur_w [NKW];
   logic [127:0] cur_key;

   // compare-process model state
   logic         pend = 1'b0;
   int           acc_cyc = 0;
   int           done_cyc = 0;
   logic [127:0] exp_ct = '0;
   logic [127:0] first_st = '0;
   logic [127:0] last_ct = '0;

   aes_cipher_state dut (
      .rst       (rst),
      .clk       (clk),
      .SBox      (sbox),
      .KExp      (kexp),
      .Data_in   (din),
      .Enable    (Enable),
      .Data_out  (dout),
      .Ready_out (Ready_out),
      .Busy_out  (Busy_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic set_key(input logic [127:0] k);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      cur_key = k;
      for (int i = 0; i < 4; i++) cur_w[i] = k[127-32*i -: 32];
      for (int i = 4; i < NKW; i++) begin
         t = cur_w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         cur_w[i] = cur_w[i-4] ^ t;
      end
      for (int i = 0; i < NKW; i++) kexp[i] = cur_w[i];
   endtask

   function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
      logic [7:0]   st  [4][4];
      logic [7:0]   tmp [4][4];
      logic [7:0]   a0, a1, a2, a3;
      logic [31:0]  w;
      logic [127:0] res;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            w = cur_w[c];
            st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[31-8*r -: 8];
         end
      for (int rnd = 1; rnd <= Nr; rnd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) tmp[r][c] = sbox[st[r][(c+r)%4]];
         st = tmp;
         if (rnd < Nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[0][c]; a1 = st[1][c]; a2 = st[2][c]; a3 = st[3][c];
               tmp[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               tmp[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               tmp[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               tmp[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
            st = tmp;
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
               w = cur_w[4*rnd+c];
               st[r][c] = st[r][c] ^ w[31-8*r -: 8];
            end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = st[r][c];
      return res;
   endfunction

   function automatic block_t to_blk(input logic [127:0] h);
      block_t b;
      for (int i = 0; i < 16; i++) b[i] = h[127-8*i -: 8];
      return b;
   endfunction

   function automatic logic [127:0] to_hex(input block_t b);
      logic [127:0] h;
      for (int i = 0; i < 16; i++) h[127-8*i -: 8] = b[i];
      return h;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- per-cycle scoreboard ----------------
   logic [127:0] exp_q [$];

   always @(negedge clk) begin
      logic exp_ready, exp_busy;
      if (!rst) begin
         check("reset_ready", 128'(Ready_out), 128'd0);
         check("reset_busy", 128'(Busy_out), 128'd0);
         check("reset_data", to_hex(dout), 128'd0);
         pend    = 1'b0;
         last_ct = '0;
         exp_q.delete();
      end else begin
         exp_ready = pend && (cyc == done_cyc);
         exp_busy  = pend && (cyc > acc_cyc) && (cyc < done_cyc);
         check("ready", 128'(Ready_out), 128'(exp_ready));
         check("busy", 128'(Busy_out), 128'(exp_busy));
         if (exp_ready) begin
            exp_ct = exp_q.pop_front();
            check("ciphertext", to_hex(dout), exp_ct);
            last_ct = exp_ct;
            pend    = 1'b0;
         end
`ifdef AES_CIPHER_OUT_REG_EN
         else check("out_hold", to_hex(dout), last_ct);
`else
         else if (pend && cyc == acc_cyc + 1) check("round0_state", to_hex(dout), first_st);
`endif
         if (!pend && Enable) begin
            pend     = 1'b1;
            acc_cyc  = cyc;
            done_cyc = cyc + LAT;
            exp_q.push_back(model_encrypt(to_hex(din)));
            first_st = to_hex(din) ^ cur_key;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_block(input logic [127:0] k, input logic [127:0] pt, output int c0);
      set_key(k);
      din    = to_blk(pt);
      Enable = 1'b1;
      c0     = cyc;
      tick();
      Enable = 1'b0;
      din    = to_blk(rand128());
   endtask

   task automatic wait_ready(input string name, input int c0, input bit jitter);
      int n;
      n = 0;
      forever begin
         if (Ready_out || n >= 4 * LAT) break;
         if (jitter) begin
            Enable = 1'($urandom_range(0, 1));
            din    = to_blk(rand128());
         end
         tick();
         n++;
      end
      Enable = 1'b0;
      if (!Ready_out) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: no Ready_out within %0d cycles", name, n);
      end else begin
         check({name, "_latency"}, 128'(cyc - c0), 128'(LAT));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c0, cnt, n;
      rst    = 1'b0;
      Enable = 1'b0;
      din    = '0;
      build_sbox();
      set_key(128'h0);

      // pin the reference model with published values
      check("sbox_00", 128'(sbox[8'h00]), 128'h63);
      check("sbox_01", 128'(sbox[8'h01]), 128'h7c);
      check("sbox_53", 128'(sbox[8'h53]), 128'hed);
      set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
      check("kexp_w43", 128'(cur_w[43]), 128'hb6630ca6);
      check("model_appb", model_encrypt(128'h3243f6a8885a308d313198a2e0370734),
            128'h3925841d02dc09fbdc118597196a0b32);
      set_key(128'h000102030405060708090a0b0c0d0e0f);
      check("model_c1", model_encrypt(128'h00112233445566778899aabbccddeeff),
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      repeat (3) tick();
      check("rst_busy_direct", 128'(Busy_out), 128'd0);
      rst = 1'b1;
      repeat (2) tick();

      // FIPS-197 C.1
      start_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, c0);
      wait_ready("fips_c1", c0, 1'b0);
      check("fips_c1_ct", to_hex(dout), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      repeat (2) tick();

      // FIPS-197 Appendix B
      start_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, c0);
      wait_ready("fips_b", c0, 1'b0);
      check("fips_b_ct", to_hex(dout), 128'h3925841d02dc09fbdc118597196a0b32);
      tick();

      // back-to-back: Enable held high for three blocks
      set_key(rand128());
      din    = to_blk(rand128());
      Enable = 1'b1;
      c0     = cyc;
      cnt    = 0;
      n      = 0;
      tick();
      while (cnt < 3 && n < 5 * LAT) begin
         if (Ready_out) begin
            cnt++;
            check("b2b_pulse_cycle", 128'(cyc - c0), 128'(cnt * LAT));
            if (cnt < 3) din = to_blk(rand128());
            else Enable = 1'b0;
         end
         if (cnt < 3) begin
            tick();
            n++;
         end
      end
      Enable = 1'b0;
      check("b2b_count", 128'(cnt), 128'd3);
      repeat (2) tick();

      // Enable pulses mid-block are ignored
      start_block(rand128(), rand128(), c0);
      for (int k = 1; k <= 9; k++) begin
         Enable = (k == 3 || k == 7);
         tick();
      end
      Enable = 1'b0;
      wait_ready("mid_enable", c0, 1'b0);
      repeat (3) tick();

      // asynchronous reset in the middle of a block
      start_block(rand128(), rand128(), c0);
      repeat (4) tick();
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_busy", 128'(Busy_out), 128'd0);
      check("async_rst_ready", 128'(Ready_out), 128'd0);
      check("async_rst_data", to_hex(dout), 128'd0);
      repeat (2) tick();
      rst = 1'b1;
      repeat (LAT) tick();
      start_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, c0);
      wait_ready("post_rst", c0, 1'b0);
      check("post_rst_ct", to_hex(dout), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      // randomized blocks with noisy Enable/Data_in while busy
      for (int b = 0; b < 25; b++) begin
         repeat ($urandom_range(0, 3)) tick();
         start_block(rand128(), rand128(), c0);
         wait_ready("random", c0, 1'b1);
      end
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
